// File: rtl/rst_req_gen.sv
// Reset requester/sequencer: merges SW/JTAG/EXT (and optional watchdog) requests into a
// sequenced peripheral-then-core active-low reset. Optional watchdog: `define RST_REQ_WDT_EN.
module rst_req_gen #(
  parameter int unsigned       HOLD_CYCLES = 16,
  parameter int unsigned       SEQ_GAP     = 4,
  parameter int unsigned       CNT_W       = 8,
  parameter logic [7:0]        SW_KEY      = 8'hA5,
  parameter int unsigned       WDT_W       = 24,
  parameter logic [WDT_W-1:0]  WDT_TIMEOUT = 24'hFFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_req,
  input  logic [7:0] sw_key,
  input  logic       jtag_req,
  input  logic       ext_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  input  logic       cause_clr,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       busy,
  output logic [4:0] cause
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT     = 2'd1,
    REL_PERIPH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(SEQ_GAP - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sw_ok;
  logic             wdt_fire;
  logic [4:0]       new_bits;
  logic             req;

  assign sw_ok = sw_req && (sw_key == SW_KEY);

`ifdef RST_REQ_WDT_EN
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_TIMEOUT - WDT_W'(1);

  logic [WDT_W-1:0] wdt_cnt;

  // A kick in the terminal cycle suppresses the fire.
  assign wdt_fire = (state == IDLE) && wdt_en && !wdt_kick && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt <= '0;
    end else if ((state != IDLE) || !wdt_en || wdt_kick || wdt_fire) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = wdt_en ^ wdt_kick;
  assign wdt_fire   = 1'b0;
`endif

  assign new_bits = {wdt_fire, ext_req, jtag_req, sw_ok, 1'b0};
  assign req      = |new_bits;

  // NOTE: every state and output register is assigned with <= so all of them update
  // together from the pre-edge values; a blocking assignment here would leak new values
  // into later statements of the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ASSERT;
      cnt          <= HOLD_LOAD;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      busy         <= 1'b1;
      cause        <= 5'b00001;
    end else begin
      cause <= cause_clr ? new_bits : (cause | new_bits);

      // Any request, in any state, restarts the full hold.
      if (req) begin
        state        <= ASSERT;
        cnt          <= HOLD_LOAD;
        periph_rst_n <= 1'b0;
        core_rst_n   <= 1'b0;
        busy         <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            periph_rst_n <= 1'b1;
            core_rst_n   <= 1'b1;
            busy         <= 1'b0;
          end
          ASSERT: begin
            if (cnt == '0) begin
              state        <= REL_PERIPH;
              cnt          <= GAP_LOAD;
              periph_rst_n <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          REL_PERIPH: begin
            if (cnt == '0) begin
              state      <= IDLE;
              core_rst_n <= 1'b1;
              busy       <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state        <= ASSERT;
            cnt          <= HOLD_LOAD;
            periph_rst_n <= 1'b0;
            core_rst_n   <= 1'b0;
            busy         <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_req_gen.sv
// Bench for rst_req_gen: directed scenarios plus random traffic against a model that
// tracks only "cycles since the last request" and a sticky cause vector.
module tb_rst_req_gen;

  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int WDT_T = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_req = 1'b0;
  logic [7:0] sw_key = 8'h00;
  logic       jtag_req = 1'b0;
  logic       ext_req = 1'b0;
  logic       wdt_en = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       cause_clr = 1'b0;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       busy;
  logic [4:0] cause;

  int total = 0;
  int bad   = 0;

  // Model: a request (or rst) in cycle L makes periph low for cycles L+1..L+HOLD and
  // core low for L+1..L+HOLD+GAP.
  int         cyc      = 0;
  int         last_req = -100000;
  logic [4:0] m_cause  = 5'b0;
  int         wdt_acc  = 0;

  rst_req_gen #(.WDT_TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst), .sw_req(sw_req), .sw_key(sw_key), .jtag_req(jtag_req),
    .ext_req(ext_req), .wdt_en(wdt_en), .wdt_kick(wdt_kick), .cause_clr(cause_clr),
    .periph_rst_n(periph_rst_n), .core_rst_n(core_rst_n), .busy(busy), .cause(cause)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_vec();
    int d;
    d = cyc - last_req;
    return {(d > HOLD), (d > HOLD + GAP), !(d > HOLD + GAP), m_cause};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {periph_rst_n, core_rst_n, busy, cause};
  endfunction

  // Advance one clock, folding this cycle's inputs into the model.
  task automatic tick();
    logic       idle_now;
    logic       fire;
    logic [4:0] bits;
    @(posedge clk);
    idle_now = (cyc - last_req) > HOLD + GAP;
    fire = 1'b0;
`ifdef RST_REQ_WDT_EN
    if (!rst && idle_now && wdt_en && !wdt_kick) begin
      if (wdt_acc == WDT_T - 1) begin
        fire = 1'b1;
        wdt_acc = 0;
      end else begin
        wdt_acc++;
      end
    end else begin
      wdt_acc = 0;
    end
`else
    wdt_acc = 0;
`endif
    bits = {fire, ext_req, jtag_req, (sw_req && sw_key == 8'hA5), 1'b0};
    if (rst) begin
      m_cause  = 5'b00001;
      last_req = cyc;
    end else begin
      m_cause = cause_clr ? bits : (m_cause | bits);
      if (bits != 5'b0) last_req = cyc;
    end
    cyc++;
    #1;
  endtask

  task automatic quiet();
    rst = 0; sw_req = 0; sw_key = 8'h00; jtag_req = 0; ext_req = 0;
    wdt_kick = 0; cause_clr = 0;
  endtask

  task automatic run_cmp(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset();
    quiet();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (dut_vec() !== 8'b0_0_1_00001) begin
        bad++;
        $display("FAIL reset_state got=%b exp=%b", dut_vec(), 8'b00100001);
      end
    end
    rst = 0;
    run_cmp("por_seq", HOLD + GAP + 5);
    total++;
    if (dut_vec() !== 8'b1_1_0_00001) begin
      bad++;
      $display("FAIL por_final got=%b exp=%b", dut_vec(), 8'b11000001);
    end
  endtask

  task automatic test_sw_key();
    int low_cnt;
    quiet();
    cause_clr = 1;
    run_cmp("cause_clr", 1);
    cause_clr = 0;
    sw_req = 1; sw_key = 8'h5A;
    run_cmp("sw_bad_key", 1);
    quiet();
    run_cmp("sw_bad_key_idle", 5);
    total++;
    if (cause !== 5'b0 || periph_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL sw_bad_key_effect cause=%b periph=%b exp cause=00000 periph=1", cause, periph_rst_n);
    end
    sw_req = 1; sw_key = 8'hA5;
    run_cmp("sw_good_key", 1);
    quiet();
    low_cnt = (periph_rst_n === 1'b0) ? 1 : 0;
    for (int i = 0; i < HOLD + GAP + 4; i++) begin
      run_cmp("sw_seq", 1);
      if (periph_rst_n === 1'b0) low_cnt++;
    end
    total++;
    if (low_cnt != HOLD || cause !== 5'b00010) begin
      bad++;
      $display("FAIL sw_hold_len low=%0d exp=%0d cause=%b exp=00010", low_cnt, HOLD, cause);
    end
  endtask

  task automatic test_jtag_hold();
    quiet();
    jtag_req = 1;
    run_cmp("jtag_held", 40);
    jtag_req = 0;
    run_cmp("jtag_release", HOLD + GAP + 4);
    total++;
    if (cause[2] !== 1'b1) begin
      bad++;
      $display("FAIL jtag_cause got=%b exp=1", cause[2]);
    end
  endtask

  task automatic test_ext_in_rel();
    logic core_seen_high;
    quiet();
    ext_req = 1;
    run_cmp("ext_first", 1);
    ext_req = 0;
    run_cmp("ext_to_rel", HOLD + 2);
    ext_req = 1;
    run_cmp("ext_in_rel", 1);
    ext_req = 0;
    core_seen_high = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      run_cmp("ext_rehold", 1);
      if (core_rst_n !== 1'b0) core_seen_high = 1'b1;
    end
    total++;
    if (core_seen_high !== 1'b0) begin
      bad++;
      $display("FAIL ext_core_glitch got=1 exp=0");
    end
    run_cmp("ext_release", GAP + 4);
  endtask

  task automatic test_simul();
    quiet();
    sw_req = 1; sw_key = 8'hA5; ext_req = 1; cause_clr = 1;
    run_cmp("simul_req", 1);
    quiet();
    run_cmp("simul_seq", HOLD + GAP + 4);
    total++;
    if (cause !== 5'b01010) begin
      bad++;
      $display("FAIL simul_cause got=%b exp=01010", cause);
    end
  endtask

  task automatic test_wdt();
    logic reset_seen;
    quiet();
    cause_clr = 1;
    run_cmp("wdt_clr", 1);
    cause_clr = 0;
    wdt_en = 1;
    run_cmp("wdt_no_kick", WDT_T + HOLD + GAP + 10);
    total++;
`ifdef RST_REQ_WDT_EN
    if (cause !== 5'b10000) begin
      bad++;
      $display("FAIL wdt_fire_cause got=%b exp=10000", cause);
    end
`else
    if (cause !== 5'b00000) begin
      bad++;
      $display("FAIL wdt_disabled_cause got=%b exp=00000", cause);
    end
`endif
    run_cmp("wdt_settle", WDT_T);
    cause_clr = 1;
    wdt_en = 0;
    run_cmp("wdt_clr2", 1);
    cause_clr = 0;
    run_cmp("wdt_idle", HOLD + GAP + 4);
    wdt_en = 1;
    reset_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wdt_kick = (i % 50 == 49);
      run_cmp("wdt_kicked", 1);
      if (periph_rst_n !== 1'b1) reset_seen = 1'b1;
    end
    wdt_kick = 0;
    wdt_en = 0;
    total++;
    if (reset_seen !== 1'b0) begin
      bad++;
      $display("FAIL wdt_kick_prevents got=1 exp=0");
    end
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 999) < 3);
      jtag_req  = ($urandom_range(0, 99) < 2);
      ext_req   = ($urandom_range(0, 99) < 2);
      sw_req    = ($urandom_range(0, 99) < 4);
      k         = $urandom_range(0, 2);
      sw_key    = (k == 0) ? 8'hA5 : (k == 1) ? 8'h5A : 8'($urandom);
      cause_clr = ($urandom_range(0, 99) < 4);
      wdt_en    = ($urandom_range(0, 99) < 95);
      wdt_kick  = ($urandom_range(0, 99) < 1);
      run_cmp("random", 1);
    end
    quiet();
    wdt_en = 0;
    run_cmp("random_tail", HOLD + GAP + 4);
  endtask

  initial begin
    test_reset();
    test_sw_key();
    test_jtag_hold();
    test_ext_in_rel();
    test_simul();
    test_wdt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
